// File: rtl/pe_ctrl_pkg.sv
// pe_ctrl_pkg: encodings shared by the PE array and its control sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMPUTE,
        ST_FEEDBACK,
        ST_COLLECT,
        ST_OUTPUT,
        ST_DRAIN,
        ST_DONE
    } pe_seq_state_t;

    // sel_cu_go_back encodings
    localparam logic [1:0] GB_NONE = 2'b00;
    localparam logic [1:0] GB_PAR  = 2'b01;
    localparam logic [1:0] GB_DONE = 2'b10;
    localparam logic [1:0] GB_IN   = 2'b11;

    // sel_adder encodings
    localparam logic [1:0] ADD_NONE = 2'b00;
    localparam logic [1:0] ADD_LANE = 2'b01;
    localparam logic [1:0] ADD_SUM  = 2'b10;

endpackage

// File: rtl/pe_seq_cmd_buf.sv
// pe_seq_cmd_buf: one-entry holding register for a command accepted while the sequencer is busy.
// Latency: data visible (full=1) the cycle after push; pop frees it on the next edge.
// Backpressure: owner must not push while full; full drives the sequencer's cmd_ready.
// Ports: clk, rst (sync, active-high); push with op/passes/fb_dst/sum in;
//        pop; full and the held op/passes/fb_dst/sum out.
module pe_seq_cmd_buf #(
    parameter int PASS_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [1:0]        push_op,
    input  logic [PASS_W-1:0] push_passes,
    input  logic              push_fb_dst,
    input  logic              push_sum,
    input  logic              pop,
    output logic              full,
    output logic [1:0]        held_op,
    output logic [PASS_W-1:0] held_passes,
    output logic              held_fb_dst,
    output logic              held_sum
);

    always_ff @(posedge clk) begin
        if (rst) begin
            full        <= 1'b0;
            held_op     <= '0;
            held_passes <= '0;
            held_fb_dst <= 1'b0;
            held_sum    <= 1'b0;
        end else if (push) begin
            full        <= 1'b1;
            held_op     <= push_op;
            held_passes <= push_passes;
            held_fb_dst <= push_fb_dst;
            held_sum    <= push_sum;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/pe_sequencer.sv
// pe_sequencer: steps PE control (sel_cu, go_back, sel_adder, save) through compute/feedback/collect/output phases.
// Latency: done at accept + P*CU_LAT + (P-1) + 3 (+ADD_LAT when summing); outputs are Moore on state.
// Backpressure: cmd_ready low while busy; with PE_SEQ_QUEUE_EN it is low only while the holding register is full.
// Ports: clk, rst (sync, active-high); cmd_valid/cmd_ready handshake with cmd_op, cmd_passes,
//        cmd_fb_dst, cmd_sum; PE controls sel_cu, sel_cu_go_back, sel_adder, is_save_cu_out; busy, done.
// Optional feature macro: PE_SEQ_QUEUE_EN (one-entry command holding register).
module pe_sequencer
    import pe_ctrl_pkg::*;
#(
    parameter int CU_LAT  = 2,
    parameter int ADD_LAT = 4,
    parameter int PASS_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [PASS_W-1:0] cmd_passes,
    input  logic              cmd_fb_dst,
    input  logic              cmd_sum,
    output logic [1:0]        sel_cu,
    output logic [1:0]        sel_cu_go_back,
    output logic [1:0]        sel_adder,
    output logic              is_save_cu_out,
    output logic              busy,
    output logic              done
);

    localparam int CNT_MAX = (CU_LAT > ADD_LAT) ? CU_LAT : ((ADD_LAT > 1) ? ADD_LAT : 1);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] CU_LAST  = CNT_W'(CU_LAT - 1);
    localparam logic [CNT_W-1:0] ADD_LAST = CNT_W'((ADD_LAT > 0) ? ADD_LAT - 1 : 0);

    pe_seq_state_t     state, state_n;
    logic [CNT_W-1:0]  lat_cnt;
    logic [PASS_W-1:0] rem_passes;
    logic [1:0]        op_q;
    logic              fb_dst_q;
    logic              sum_q;

    logic              accept;
    logic              start;
    logic [1:0]        src_op;
    logic [PASS_W-1:0] src_passes;
    logic              src_fb_dst;
    logic              src_sum;

    assign accept = cmd_valid & cmd_ready;

`ifdef PE_SEQ_QUEUE_EN
    logic              buf_full;
    logic              buf_push;
    logic              buf_pop;
    logic [1:0]        buf_op;
    logic [PASS_W-1:0] buf_passes;
    logic              buf_fb_dst;
    logic              buf_sum;

    pe_seq_cmd_buf #(.PASS_W(PASS_W)) u_cmd_buf (
        .clk         (clk),
        .rst         (rst),
        .push        (buf_push),
        .push_op     (cmd_op),
        .push_passes (cmd_passes),
        .push_fb_dst (cmd_fb_dst),
        .push_sum    (cmd_sum),
        .pop         (buf_pop),
        .full        (buf_full),
        .held_op     (buf_op),
        .held_passes (buf_passes),
        .held_fb_dst (buf_fb_dst),
        .held_sum    (buf_sum)
    );

    assign cmd_ready = ~rst & ~buf_full;
`else
    assign cmd_ready = ~rst & (state == ST_IDLE);
`endif

    always_comb begin
        state_n        = state;
        sel_cu         = op_q;
        sel_cu_go_back = GB_NONE;
        sel_adder      = ADD_NONE;
        is_save_cu_out = 1'b0;
        busy           = 1'b1;
        done           = 1'b0;
        start          = 1'b0;
        src_op         = cmd_op;
        src_passes     = cmd_passes;
        src_fb_dst     = cmd_fb_dst;
        src_sum        = cmd_sum;
`ifdef PE_SEQ_QUEUE_EN
        buf_pop        = 1'b0;
        buf_push       = 1'b0;
`endif

        case (state)
            ST_IDLE: begin
                sel_cu = 2'b00;
                busy   = 1'b0;
                start  = accept;
            end
            ST_COMPUTE: begin
                if (lat_cnt == CU_LAST) begin
                    state_n = (rem_passes > PASS_W'(1)) ? ST_FEEDBACK : ST_COLLECT;
                end
            end
            ST_FEEDBACK: begin
                is_save_cu_out = 1'b1;
                sel_cu_go_back = fb_dst_q ? GB_IN : GB_PAR;
                state_n        = ST_COMPUTE;
            end
            ST_COLLECT: begin
                sel_cu_go_back = GB_DONE;
                state_n        = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                sel_adder = sum_q ? ADD_SUM : ADD_LANE;
                state_n   = (sum_q && (ADD_LAT > 0)) ? ST_DRAIN : ST_DONE;
            end
            ST_DRAIN: begin
                if (lat_cnt == ADD_LAST) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
`ifdef PE_SEQ_QUEUE_EN
                // Chain straight into the next command so busy never drops;
                // a command arriving on this very cycle bypasses the register.
                if (buf_full) begin
                    start      = 1'b1;
                    buf_pop    = 1'b1;
                    src_op     = buf_op;
                    src_passes = buf_passes;
                    src_fb_dst = buf_fb_dst;
                    src_sum    = buf_sum;
                end else begin
                    start = accept;
                end
`endif
            end
            default: state_n = ST_IDLE;
        endcase

        if (start) begin
            state_n = ST_COMPUTE;
        end
`ifdef PE_SEQ_QUEUE_EN
        buf_push = accept & ~start;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            lat_cnt    <= '0;
            rem_passes <= '0;
            op_q       <= 2'b00;
            fb_dst_q   <= 1'b0;
            sum_q      <= 1'b0;
        end else begin
            state <= state_n;

            // One counter serves both CU latency and adder drain; it restarts
            // on every state change, including FEEDBACK -> COMPUTE.
            if ((state_n == state) && ((state == ST_COMPUTE) || (state == ST_DRAIN))) begin
                lat_cnt <= lat_cnt + CNT_W'(1);
            end else begin
                lat_cnt <= '0;
            end

            if (start) begin
                op_q       <= src_op;
                fb_dst_q   <= src_fb_dst;
                sum_q      <= src_sum;
                rem_passes <= (src_passes == '0) ? PASS_W'(1) : src_passes;
            end else if (state == ST_FEEDBACK) begin
                rem_passes <= rem_passes - PASS_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pe_sequencer.sv
// tb_pe_sequencer: self-checking bench for pe_sequencer against a phase-list reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pe_sequencer;
    localparam int CU_LAT  = 2;
    localparam int ADD_LAT = 4;
    localparam int PASS_W  = 4;

    // Phase codes of the reference model
    localparam int PH_C = 0;  // compute
    localparam int PH_F = 1;  // feedback
    localparam int PH_K = 2;  // collect
    localparam int PH_O = 3;  // output
    localparam int PH_D = 4;  // adder drain
    localparam int PH_X = 5;  // done

    localparam logic [9:0] IDLE_VEC = 10'b01_00_00_00_0_0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'b00;
    logic [PASS_W-1:0] cmd_passes = '0;
    logic              cmd_fb_dst = 1'b0;
    logic              cmd_sum = 1'b0;
    logic [1:0]        sel_cu;
    logic [1:0]        sel_cu_go_back;
    logic [1:0]        sel_adder;
    logic              is_save_cu_out;
    logic              busy;
    logic              done;

    int n_cmp = 0;
    int n_bad = 0;
    int ph[$];

    always #5 clk = ~clk;

    pe_sequencer #(.CU_LAT(CU_LAT), .ADD_LAT(ADD_LAT), .PASS_W(PASS_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_passes     (cmd_passes),
        .cmd_fb_dst     (cmd_fb_dst),
        .cmd_sum        (cmd_sum),
        .sel_cu         (sel_cu),
        .sel_cu_go_back (sel_cu_go_back),
        .sel_adder      (sel_adder),
        .is_save_cu_out (is_save_cu_out),
        .busy           (busy),
        .done           (done)
    );

    // {busy, cmd_ready, sel_cu, go_back, sel_adder, save, done}
    function automatic logic [9:0] obs_vec();
        return {busy, cmd_ready, sel_cu, sel_cu_go_back, sel_adder, is_save_cu_out, done};
    endfunction

    // Phase sequence of one command: passes of CU_LAT compute cycles separated
    // by one feedback cycle, then collect, output, optional drain, done.
    function automatic void build_phases(input int passes, input logic sum);
        int p;
        p = (passes == 0) ? 1 : passes;
        ph.delete();
        for (int i = 0; i < p; i++) begin
            for (int j = 0; j < CU_LAT; j++) ph.push_back(PH_C);
            if (i < p - 1) ph.push_back(PH_F);
        end
        ph.push_back(PH_K);
        ph.push_back(PH_O);
        if (sum) for (int j = 0; j < ADD_LAT; j++) ph.push_back(PH_D);
        ph.push_back(PH_X);
    endfunction

    function automatic logic [9:0] exp_vec(input int code, input logic [1:0] op,
                                           input logic fb, input logic sum, input logic rdy);
        logic [1:0] gb, ad;
        logic sv, dn;
        gb = 2'b00; ad = 2'b00; sv = 1'b0; dn = 1'b0;
        case (code)
            PH_F: begin sv = 1'b1; gb = fb ? 2'b11 : 2'b01; end
            PH_K: gb = 2'b10;
            PH_O: ad = sum ? 2'b10 : 2'b01;
            PH_X: dn = 1'b1;
            default: ;
        endcase
        return {1'b1, rdy, op, gb, ad, sv, dn};
    endfunction

    task automatic drive_junk();
`ifdef PE_SEQ_QUEUE_EN
        cmd_valid = 1'b0;
`else
        cmd_valid = 1'($urandom);
`endif
        cmd_op     = 2'($urandom);
        cmd_passes = PASS_W'($urandom);
        cmd_fb_dst = 1'($urandom);
        cmd_sum    = 1'($urandom);
    endtask

    // Entered and left just after a negedge of an idle cycle.
    task automatic run_cmd(input logic [1:0] op, input int passes, input logic fb,
                           input logic sum, input string name, output int fb_seen);
        logic rdy_busy;
`ifdef PE_SEQ_QUEUE_EN
        rdy_busy = 1'b1;
`else
        rdy_busy = 1'b0;
`endif
        fb_seen = 0;
        build_phases(passes, sum);
        cmd_valid = 1'b1; cmd_op = op; cmd_passes = PASS_W'(passes);
        cmd_fb_dst = fb; cmd_sum = sum;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s accept_ready: got %b want 1", name, cmd_ready);
        end
        @(posedge clk);
        for (int i = 0; i < ph.size(); i++) begin
            @(negedge clk);
            drive_junk();
            if (is_save_cu_out === 1'b1) fb_seen++;
            n_cmp++;
            if (obs_vec() !== exp_vec(ph[i], op, fb, sum, rdy_busy)) begin
                n_bad++;
                $display("FAIL %s cycle T+%0d: got %b want %b", name, i + 1, obs_vec(),
                         exp_vec(ph[i], op, fb, sum, rdy_busy));
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_cmp++;
        if (obs_vec() !== IDLE_VEC) begin
            n_bad++;
            $display("FAIL %s after_done: got %b want %b", name, obs_vec(), IDLE_VEC);
        end
    endtask

    task automatic idle_cycles(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== IDLE_VEC) begin
                n_bad++;
                $display("FAIL %s idle: got %b want %b", name, obs_vec(), IDLE_VEC);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (obs_vec() !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_held: got %b want %b", obs_vec(), 10'b0);
        end
        rst = 1'b0;
        idle_cycles(2, "reset_release");
    endtask

    task automatic test_basic();
        int f;
        run_cmd(2'b01, 1, 1'b0, 1'b0, "basic_p1", f);
        run_cmd(2'b10, 3, 1'b1, 1'b1, "basic_p3_sum", f);
        n_cmp++;
        if (f !== 2) begin
            n_bad++;
            $display("FAIL basic_p3_fb_count: got %0d want 2", f);
        end
    endtask

    task automatic test_pass_bounds();
        int f;
        run_cmd(2'b11, 0, 1'b0, 1'b0, "passes0", f);
        n_cmp++;
        if (f !== 0) begin
            n_bad++;
            $display("FAIL passes0_fb_count: got %0d want 0", f);
        end
        run_cmd(2'b01, 15, 1'b0, 1'b1, "passes15", f);
        n_cmp++;
        if (f !== 14) begin
            n_bad++;
            $display("FAIL passes15_fb_count: got %0d want 14", f);
        end
    endtask

    task automatic test_reset_abort();
        int f;
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_passes = PASS_W'(3);
        cmd_fb_dst = 1'b1; cmd_sum = 1'b1;
        @(posedge clk);
        // Second pass computes at T+CU_LAT+2; assert reset in that cycle.
        for (int i = 1; i <= CU_LAT + 2; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (obs_vec() !== 10'b0) begin
            n_bad++;
            $display("FAIL abort_outputs: got %b want %b", obs_vec(), 10'b0);
        end
        rst = 1'b0;
        idle_cycles(20, "abort_no_done");
        run_cmd(2'b11, 2, 1'b0, 1'b1, "after_abort", f);
    endtask

    task automatic test_random();
        int f;
        logic [1:0] op;
        int p;
        logic fb, sm;
        for (int k = 0; k < 20; k++) begin
            op = 2'($urandom);
            p  = int'($urandom_range(0, 15));
            fb = 1'($urandom);
            sm = 1'($urandom);
            run_cmd(op, p, fb, sm, "random", f);
            n_cmp++;
            if (f !== ((p == 0) ? 0 : p - 1)) begin
                n_bad++;
                $display("FAIL random_fb_count: passes %0d got %0d", p, f);
            end
            if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)), "random_gap");
        end
    endtask

    task automatic test_back_to_back();
        int f;
        run_cmd(2'b01, 2, 1'b1, 1'b0, "b2b_a", f);
        run_cmd(2'b10, 1, 1'b0, 1'b1, "b2b_b", f);
        run_cmd(2'b11, 1, 1'b0, 1'b0, "b2b_c", f);
    endtask

`ifdef PE_SEQ_QUEUE_EN
    task automatic test_queue();
        int pa[$];
        int pb[$];
        int na;
        logic [9:0] e;
        build_phases(2, 1'b0); pa = ph;
        build_phases(1, 1'b1); pb = ph;
        na = pa.size();
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_passes = PASS_W'(2);
        cmd_fb_dst = 1'b0; cmd_sum = 1'b0;
        @(posedge clk);
        for (int i = 0; i < na + pb.size(); i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (i < na) e = exp_vec(pa[i], 2'b11, 1'b0, 1'b0, (i < 2));
            else        e = exp_vec(pb[i - na], 2'b01, 1'b1, 1'b1, 1'b1);
            n_cmp++;
            if (obs_vec() !== e) begin
                n_bad++;
                $display("FAIL queue cycle T+%0d: got %b want %b", i + 1, obs_vec(), e);
            end
            if (i == 1) begin
                cmd_valid = 1'b1; cmd_op = 2'b01; cmd_passes = PASS_W'(1);
                cmd_fb_dst = 1'b1; cmd_sum = 1'b1;
            end
        end
        idle_cycles(2, "queue_end");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_pass_bounds();
        test_reset_abort();
        test_back_to_back();
        test_random();
`ifdef PE_SEQ_QUEUE_EN
        test_queue();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
